// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: glyph encodings (bit0 = a, 1 = lit) and common widths.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Lit-segment pattern for each hex digit; also used by encoder-side blocks.
  function automatic logic [SEG_W-1:0] seg7_glyph(input logic [NIB_W-1:0] v);
    logic [SEG_W-1:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of a lit seven-segment pattern into hex value / blank / error.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] lit,
  output logic [NIB_W-1:0] value,
  output logic             blank,
  output logic             error
);

  always_comb begin
    value = '0;
    blank = 1'b0;
    error = 1'b1;
    if (lit == SEG_BLANK) begin
      blank = 1'b1;
      error = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (lit == seg7_glyph(NIB_W'(i))) begin
          value = NIB_W'(i);
          error = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed seven-segment display: debounces each strobed digit, keeps a
// per-digit snapshot and streams changes through a valid/ready update port.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter bit          INVERT        = 1'b1,
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 seg_in,
  input  logic [DIGITS-1:0]          dig_sel,
  output logic [3:0]                 m_value,
  output logic [$clog2(DIGITS)-1:0]  m_index,
  output logic                       m_blank,
  output logic                       m_error,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [4*DIGITS-1:0]        digits_out,
  output logic [DIGITS-1:0]          digits_valid,
  output logic                       overflow
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic {IDLE, HOLD} state_t;

  logic [SEG_W-1:0]             seg_s1, seg_s2, seg_prev;
  logic [DIGITS-1:0]            dig_s1, dig_s2, dig_prev;
  logic [CNT_W-1:0]             cnt;
  logic                         fired;
  state_t                       state;
  logic [DIGITS-1:0][NIB_W-1:0] snap;

  logic [SEG_W-1:0] lit_c;
  logic [NIB_W-1:0] dec_value_c;
  logic             dec_blank_c, dec_error_c;
  logic [IDX_W-1:0] idx_c;
  logic             same_c, onehot_c, capture_c, update_c, legal_c;

  // Two-flop synchronizers for the asynchronous display lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1 <= '0;
      seg_s2 <= '0;
      dig_s1 <= '0;
      dig_s2 <= '0;
    end else begin
      seg_s1 <= seg_in;
      seg_s2 <= seg_s1;
      dig_s1 <= dig_sel;
      dig_s2 <= dig_s1;
    end
  end

  assign lit_c    = seg_s2 ^ {SEG_W{INVERT}};
  assign same_c   = (seg_s2 == seg_prev) && (dig_s2 == dig_prev);
  assign onehot_c = $onehot(dig_s2);

  always_comb begin
    idx_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dig_s2[i]) idx_c = idx_c | IDX_W'(i);
    end
  end

  seg7_pattern_decode u_decode (
    .lit   (lit_c),
    .value (dec_value_c),
    .blank (dec_blank_c),
    .error (dec_error_c)
  );

  // Capture fires on the edge where the stability count reaches its target.
  assign capture_c = same_c && onehot_c && !fired && (cnt == CNT_MAX - CNT_W'(1));
  assign update_c  = capture_c && (dec_blank_c || dec_error_c ||
                                   (dec_value_c != snap[idx_c]) || !digits_valid[idx_c]);
  assign legal_c   = !dec_blank_c && !dec_error_c;

  // Stability counter; `fired` disarms capture until the inputs change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_prev <= '0;
      dig_prev <= '0;
      cnt      <= '0;
      fired    <= 1'b0;
    end else begin
      seg_prev <= seg_s2;
      dig_prev <= dig_s2;
      if (!same_c) begin
        cnt   <= '0;
        fired <= 1'b0;
      end else if (!onehot_c) begin
        cnt <= '0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (capture_c) fired <= 1'b1;
      end
    end
  end

  // Snapshot follows every legal update, including ones dropped from the stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap         <= '0;
      digits_valid <= '0;
    end else if (update_c && legal_c) begin
      snap[idx_c]         <= dec_value_c;
      digits_valid[idx_c] <= 1'b1;
    end
  end

  assign digits_out = snap;

  // Update stream: holds one beat; updates arriving while stalled are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      m_valid  <= 1'b0;
      m_value  <= '0;
      m_index  <= '0;
      m_blank  <= 1'b0;
      m_error  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (update_c) begin
            m_value <= dec_value_c;
            m_index <= idx_c;
            m_blank <= dec_blank_c;
            m_error <= dec_error_c;
            m_valid <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (m_ready) begin
            if (update_c) begin
              m_value <= dec_value_c;
              m_index <= idx_c;
              m_blank <= dec_blank_c;
              m_error <= dec_error_c;
            end else begin
              m_valid <= 1'b0;
              state   <= IDLE;
            end
          end else if (update_c) begin
            overflow <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus randomized phases against a phase-level model.
module tb_seg7_capture;

  localparam int unsigned DIGITS = 8;
  localparam int unsigned S      = 4;

  typedef struct packed {
    logic [3:0] value;
    logic [2:0] index;
    logic       blank;
    logic       error;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic [7:0]  dig_sel;
  logic [3:0]  m_value;
  logic [2:0]  m_index;
  logic        m_blank, m_error, m_valid, m_ready;
  logic [31:0] digits_out;
  logic [7:0]  digits_valid;
  logic        overflow;

  int tests_run    = 0;
  int tests_failed = 0;

  beat_t      obs_q[$];
  beat_t      exp_q[$];
  logic [3:0] msnap [8];
  logic [7:0] mvld;
  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_capture #(.INVERT(1'b1), .DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .seg_in       (seg_in),
    .dig_sel      (dig_sel),
    .m_value      (m_value),
    .m_index      (m_index),
    .m_blank      (m_blank),
    .m_error      (m_error),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .digits_out   (digits_out),
    .digits_valid (digits_valid),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Record every accepted beat.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready)
      obs_q.push_back(beat_t'{m_value, m_index, m_blank, m_error});
  end

  function automatic logic [6:0] seg_of(input logic [6:0] lit);
    return ~lit;
  endfunction

  function automatic beat_t model_beat(input logic [6:0] lit, input logic [2:0] idx);
    beat_t b;
    b.value = 4'h0;
    b.index = idx;
    b.blank = (lit == 7'h00);
    b.error = (lit != 7'h00);
    for (int i = 0; i < 16; i++)
      if (glyph_tab[i] == lit) begin
        b.value = 4'(i);
        b.error = 1'b0;
      end
    return b;
  endfunction

  // Apply one input phase for n sampling edges.
  task automatic hold(input logic [6:0] s, input logic [7:0] d, input int n);
    @(negedge clk);
    seg_in  = s;
    dig_sel = d;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    hold(7'h7F, 8'h00, n);
  endtask

  // Model: a one-hot phase held at least S+1 edges captures exactly once.
  task automatic model_phase(input logic [6:0] s, input logic [7:0] d, input int n);
    beat_t b;
    logic [2:0] idx;
    if (n >= int'(S) + 1 && $countones(d) == 1) begin
      idx = 3'h0;
      for (int i = 0; i < 8; i++) if (d[i]) idx = 3'(i);
      b = model_beat(~s, idx);
      if (b.blank || b.error || b.value != msnap[idx] || !mvld[idx]) begin
        exp_q.push_back(b);
        if (!b.blank && !b.error) begin
          msnap[idx] = b.value;
          mvld[idx]  = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; seg_in = 7'h7F; dig_sel = 8'h00; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    tests_run++;
    if ({m_value, m_index, m_blank, m_error} !== 9'h0) begin
      tests_failed++; $display("FAIL reset_beat: got %h want 0", {m_value, m_index, m_blank, m_error});
    end
    tests_run++;
    if (digits_out !== 32'h0 || digits_valid !== 8'h0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_snapshot: digits_out=%h valid=%h ovf=%b want 0", digits_out, digits_valid, overflow);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    obs_q.delete();
    @(negedge clk);
    seg_in = 7'h24; dig_sel = 8'h04;
    for (int e = 0; e <= int'(S) + 3; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (m_valid !== (e == int'(S) + 2)) begin
        tests_failed++; $display("FAIL basic_latency edge %0d: m_valid=%b want %b", e, m_valid, e == int'(S) + 2);
      end
      if (e == int'(S) + 2) begin
        tests_run++;
        if ({m_value, m_index, m_blank, m_error} !== {4'h2, 3'h2, 1'b0, 1'b0}) begin
          tests_failed++;
          $display("FAIL basic_beat: value=%h index=%0d blank=%b error=%b want 2/2/0/0", m_value, m_index, m_blank, m_error);
        end
        tests_run++;
        if (digits_out[11:8] !== 4'h2 || digits_valid !== 8'h04) begin
          tests_failed++; $display("FAIL basic_snapshot: nibble=%h valid=%h want 2/04", digits_out[11:8], digits_valid);
        end
      end
    end
    idle(S + 3);
    tests_run++;
    if (obs_q.size() != 1) begin tests_failed++; $display("FAIL basic_count: got %0d beats want 1", obs_q.size()); end
  endtask

  task automatic test_short_hold;
    obs_q.delete();
    hold(seg_of(7'h3F), 8'h01, S - 1);
    hold(seg_of(7'h06), 8'h01, S - 1);
    hold(seg_of(7'h5B), 8'h01, S);
    idle(S + 4);
    tests_run++;
    if (obs_q.size() != 0 || digits_valid !== 8'h04) begin
      tests_failed++; $display("FAIL short_hold: beats=%0d valid=%h want 0/04", obs_q.size(), digits_valid);
    end
    hold(seg_of(7'h5B), 8'h01, S + 1);
    idle(S + 4);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++; $display("FAIL min_hold_count: beats=%0d want 1", obs_q.size());
    end else if (obs_q[0] !== beat_t'{4'h2, 3'h0, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL min_hold_beat: got %h want %h", obs_q[0], beat_t'{4'h2, 3'h0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_restrobe;
    obs_q.delete();
    hold(seg_of(7'h4F), 8'h02, S + 3);
    idle(S + 3);
    hold(seg_of(7'h4F), 8'h02, S + 3);
    idle(S + 3);
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== beat_t'{4'h3, 3'h1, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL restrobe: beats=%0d first=%h want 1 beat of 3 at index 1", obs_q.size(), obs_q[0]);
    end
    hold(seg_of(7'h01), 8'h02, S + 3);
    idle(S + 3);
    hold(seg_of(7'h00), 8'h02, S + 3);
    idle(S + 3);
    tests_run++;
    if (obs_q.size() != 3) begin
      tests_failed++; $display("FAIL error_blank_count: beats=%0d want 3", obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[1] !== beat_t'{4'h0, 3'h1, 1'b0, 1'b1}) begin
        tests_failed++; $display("FAIL error_beat: got %h want %h", obs_q[1], beat_t'{4'h0, 3'h1, 1'b0, 1'b1});
      end
      tests_run++;
      if (obs_q[2] !== beat_t'{4'h0, 3'h1, 1'b1, 1'b0}) begin
        tests_failed++; $display("FAIL blank_beat: got %h want %h", obs_q[2], beat_t'{4'h0, 3'h1, 1'b1, 1'b0});
      end
    end
    tests_run++;
    if (digits_out[7:4] !== 4'h3 || digits_valid !== 8'h07) begin
      tests_failed++; $display("FAIL error_snapshot: nibble=%h valid=%h want 3/07", digits_out[7:4], digits_valid);
    end
  endtask

  task automatic test_stall;
    obs_q.delete();
    m_ready = 1'b0;
    hold(seg_of(7'h77), 8'h08, S + 3);
    @(negedge clk);
    seg_in = seg_of(7'h6D); dig_sel = 8'h08;
    for (int e = 0; e < int'(S) + 4; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (m_valid !== 1'b1 || m_value !== 4'hA || m_index !== 3'h3 || m_blank !== 1'b0 || m_error !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_stable edge %0d: valid=%b value=%h index=%0d want 1/A/3", e, m_valid, m_value, m_index);
      end
    end
    tests_run++;
    if (overflow !== 1'b1 || digits_out[15:12] !== 4'h5 || digits_valid[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_drop: ovf=%b nibble=%h valid3=%b want 1/5/1", overflow, digits_out[15:12], digits_valid[3]);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL stall_release: m_valid=%b want 0", m_valid); end
    idle(S + 3);
    tests_run++;
    if (obs_q.size() != 1 || obs_q[0] !== beat_t'{4'hA, 3'h3, 1'b0, 1'b0}) begin
      tests_failed++; $display("FAIL stall_beats: count=%0d first=%h want 1 beat A at 3", obs_q.size(), obs_q[0]);
    end
  endtask

  task automatic test_not_onehot;
    obs_q.delete();
    hold(seg_of(7'h3F), 8'h06, S + 4);
    hold(seg_of(7'h06), 8'h00, S + 4);
    hold(seg_of(7'h5B), 8'hFF, S + 4);
    idle(S + 3);
    tests_run++;
    if (obs_q.size() != 0 || m_valid !== 1'b0) begin
      tests_failed++; $display("FAIL not_onehot: beats=%0d valid=%b want 0/0", obs_q.size(), m_valid);
    end
  endtask

  task automatic test_reset_in_hold;
    m_ready = 1'b0;
    hold(seg_of(7'h66), 8'h20, S + 3);
    @(negedge clk);
    tests_run++;
    if (m_valid !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_hold: m_valid=%b want 1", m_valid); end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || {m_value, m_index, m_blank, m_error} !== 9'h0 ||
        digits_out !== 32'h0 || digits_valid !== 8'h0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: valid=%b beat=%h digits=%h dv=%h ovf=%b want all 0",
               m_valid, {m_value, m_index, m_blank, m_error}, digits_out, digits_valid, overflow);
    end
    @(negedge clk);
    rst = 1'b0; m_ready = 1'b1;
    for (int e = 0; e <= int'(S) + 2; e++) begin
      @(posedge clk); #1;
      tests_run++;
      if (m_valid !== (e == int'(S) + 2)) begin
        tests_failed++; $display("FAIL post_reset_latency edge %0d: m_valid=%b want %b", e, m_valid, e == int'(S) + 2);
      end
    end
    tests_run++;
    if (m_value !== 4'h4 || m_index !== 3'h5) begin
      tests_failed++; $display("FAIL post_reset_beat: value=%h index=%0d want 4/5", m_value, m_index);
    end
    idle(S + 3);
  endtask

  task automatic test_random;
    logic [6:0]  s, ps;
    logic [7:0]  d, pd;
    logic [31:0] exp_do;
    int          n, r, k;
    @(negedge clk); rst = 1'b1; seg_in = 7'h7F; dig_sel = 8'h00; m_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) msnap[i] = 4'h0;
    mvld = 8'h00;
    obs_q.delete();
    exp_q.delete();
    ps = 7'h7F; pd = 8'h00;
    for (int p = 0; p < 80; p++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       d = 8'h01 << $urandom_range(0, 7);
      else if (r == 7) d = 8'h00;
      else             d = 8'($urandom);
      k = int'($urandom_range(0, 19));
      if (k < 16)       s = ~glyph_tab[k];
      else if (k == 16) s = 7'h7F;
      else              s = 7'($urandom);
      if (s == ps && d == pd) s = s ^ 7'h40;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, S)) : int'($urandom_range(S + 1, S + 6));
      model_phase(s, d, n);
      hold(s, d, n);
      ps = s; pd = d;
    end
    idle(S + 4);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++; $display("FAIL random_count: got %0d beats want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests_run++;
      if (obs_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL random_beat %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 8; i++) exp_do[i*4 +: 4] = msnap[i];
    tests_run++;
    if (digits_out !== exp_do || digits_valid !== mvld) begin
      tests_failed++;
      $display("FAIL random_snapshot: digits=%h dv=%h want %h/%h", digits_out, digits_valid, exp_do, mvld);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_hold();
    test_restrobe();
    test_stall();
    test_not_onehot();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 SHALL have parameter INVERT, default 1, meaning segment inputs are active-low; when 0, they are active-high.
REQ-002 SHALL have parameter DIGITS, default 8, meaning the number of multiplexed digit positions (range 2..16).
REQ-003 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive equal synchronized samples required before a capture (range 2..255).
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-006 SHALL have port seg_in, input, width 7: segment lines; bit0 = a, bit6 = g; asynchronous to clk.
REQ-007 SHALL have port dig_sel, input, width DIGITS: digit strobes, active-high; asynchronous to clk.
REQ-008 SHALL have port m_value, output, width 4: decoded hex nibble.
REQ-009 SHALL have port m_index, output, width clog2(DIGITS): digit position of m_value.
REQ-010 SHALL have port m_blank, output, width 1: the pattern was all segments off.
REQ-011 SHALL have port m_error, output, width 1: the pattern was not a legal glyph.
REQ-012 SHALL have port m_valid, output, width 1: update-stream valid.
REQ-013 SHALL have port m_ready, input, width 1: update-stream ready.
REQ-014 SHALL have port digits_out, output, width 4*DIGITS: snapshot; nibble i = last legal value of digit i.
REQ-015 SHALL have port digits_valid, output, width DIGITS: digit i has captured at least one legal glyph.
REQ-016 SHALL have port overflow, output, width 1: sticky flag; an update was dropped while the stream was stalled.

Function
REQ-017 SHALL pass seg_in and dig_sel through a two-flop synchronizer; all further logic SHALL use the synchronized copies.
REQ-018 SHALL XOR-normalize segments when INVERT=1, so that 1 = segment lit.
REQ-019 SHALL decode lit patterns (hex, bit0=a) as follows: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
REQ-020 SHALL decode pattern 00 as blank with value 0, and any other unlisted pattern as error with value 0.
REQ-021 SHALL increment a stability counter, saturating at STABLE_CYCLES, each cycle the synchronized {dig_sel,seg} equals the previous cycle's; any difference SHALL clear it to 0 and re-arm capture.
REQ-022 SHALL hold the counter at 0 with no capture while dig_sel is zero or not one-hot.
REQ-023 SHALL fire exactly one capture event when the counter reaches STABLE_CYCLES while armed, then disarm until the inputs change.
REQ-024 SHALL, on a capture event, generate an update only if the pattern is blank, is error, or its value differs from the stored nibble, or digits_valid[index]=0.
REQ-025 SHALL, for a legal-glyph update, write digits_out and set digits_valid[index] on the same edge that presents the update; blank and error updates SHALL leave the snapshot unchanged.
REQ-026 SHALL implement a stream FSM with states IDLE and HOLD: an update in IDLE loads m_* and moves to HOLD; in HOLD with m_valid&&m_ready, the FSM SHALL go to IDLE, or reload and stay in HOLD if an update occurs in the same cycle.
REQ-027 SHALL keep m_value, m_index, m_blank and m_error stable while m_valid=1 and m_ready=0.
REQ-028 SHALL, on an update arriving in HOLD without a handshake, drop it from the stream, still update the snapshot, and set overflow.
REQ-029 SHALL produce its first m_valid at edge 2+STABLE_CYCLES, counting inputs applied before edge 0 and held.

Reset
REQ-030 SHALL, on rst, asynchronously clear synchronizers, counter, arm flag, FSM (to IDLE), m_valid, m_value, m_index, m_blank, m_error, digits_out, digits_valid and overflow to 0, and re-arm capture.
REQ-031 SHALL discard any pending update when rst asserts mid-operation; the first capture after release SHALL take the full latency of REQ-029.

Structure
REQ-032 SHALL place the glyph constants of REQ-019 in shared package seg7_pkg, reused by encoder-side blocks.
REQ-033 SHALL factor the combinational decode into sub-module seg7_pattern_decode (7-bit lit pattern in; value, blank and error out).

Verification
REQ-034 SHALL cover: INVERT=1, seg_in=7'h24 (lit 5B), dig_sel=8'h04, m_ready=1 -> one beat value=2, index=2, blank=0, error=0; digits_out[11:8]=2.
REQ-035 SHALL cover: glyph held for STABLE_CYCLES-1 cycles, then changed -> no update.
REQ-036 SHALL cover: same glyph re-strobed on the same digit -> no second update; lit pattern 7'h01 -> error=1 with snapshot unchanged.
REQ-037 SHALL cover: m_ready=0 with two distinct captures -> first beat held stable, second dropped, overflow=1, snapshot holds second value.
REQ-038 SHALL cover: dig_sel=8'h06 or 8'h00 -> no update ever.
REQ-039 SHALL cover: rst pulse during HOLD -> m_valid=0 immediately, all outputs 0.
